// File: rtl/module_cla_arbiter.sv
// Two-port round-robin sequencer sharing one carry-lookahead adder.
// Each port runs IDLE -> INFLIGHT -> RESP; results are held per port until consumed.

module module_cla_8bits #(
  parameter int WIDTH2 = 64
) (
  input  logic [WIDTH2-1:0] a_pi,
  input  logic [WIDTH2-1:0] b_pi,
  output logic [WIDTH2:0]   sum_po
);
  localparam int NB = (WIDTH2 + 7) / 8;
  localparam int PW = NB * 8;

  logic [PW-1:0] w_g;
  logic [PW-1:0] w_p;

  assign w_g = PW'(a_pi) & PW'(b_pi);
  assign w_p = PW'(a_pi) ^ PW'(b_pi);

  // Block generate/propagate per 8-bit group feeds the group carry chain;
  // bit carries inside each group are then derived from the group carry-in.
  always_comb begin : carry_tree
    logic [NB:0] bc;
    logic [PW:0] c;
    logic        bg;
    logic        bp;
    bc = '0;
    c  = '0;
    for (int k = 0; k < NB; k++) begin
      bg = 1'b0;
      bp = 1'b1;
      for (int j = 0; j < 8; j++) begin
        bg = w_g[k*8+j] | (w_p[k*8+j] & bg);
        bp = bp & w_p[k*8+j];
      end
      bc[k+1] = bg | (bp & bc[k]);
    end
    for (int k = 0; k < NB; k++) begin
      c[k*8] = bc[k];
      for (int j = 0; j < 8; j++) begin
        c[k*8+j+1] = w_g[k*8+j] | (w_p[k*8+j] & c[k*8+j]);
      end
    end
    c[PW]  = bc[NB];
    sum_po = {c[WIDTH2], w_p[WIDTH2-1:0] ^ c[WIDTH2-1:0]};
  end
endmodule

module module_cla_arbiter #(
  parameter int WIDTH2 = 64
) (
  input  logic              clk_pi,
  input  logic              rst_pi,
  input  logic              req0_valid_pi,
  output logic              req0_ready_po,
  input  logic [WIDTH2-1:0] req0_a_pi,
  input  logic [WIDTH2-1:0] req0_b_pi,
  output logic              rsp0_valid_po,
  input  logic              rsp0_ready_pi,
  output logic [WIDTH2:0]   rsp0_result_po,
  input  logic              req1_valid_pi,
  output logic              req1_ready_po,
  input  logic [WIDTH2-1:0] req1_a_pi,
  input  logic [WIDTH2-1:0] req1_b_pi,
  output logic              rsp1_valid_po,
  input  logic              rsp1_ready_pi,
  output logic [WIDTH2:0]   rsp1_result_po,
  output logic [1:0]        dbg_state0_po,
  output logic [1:0]        dbg_state1_po,
  output logic              dbg_stage_valid_po
);
  // Handshakes: a transfer happens on the rising edge where valid && ready are
  // both high; valid may not depend on ready, ready only rises when valid is high.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_INFLIGHT = 2'd1,
    ST_RESP     = 2'd2
  } state_t;

  state_t              r_state0, r_state1;
  state_t              w_state0_nxt, w_state1_nxt;
  logic                r_last_grant;
  logic                r_stage_valid;
  logic                r_stage_tag;
  logic [WIDTH2-1:0]   r_stage_a, r_stage_b;
  logic [WIDTH2:0]     r_result0, r_result1;
  logic [WIDTH2:0]     w_sum;
  logic                w_elig0, w_elig1;
  logic                w_grant0, w_grant1;
  logic                w_hs;

  module_cla_8bits #(.WIDTH2(WIDTH2)) u_cla (
    .a_pi   (r_stage_a),
    .b_pi   (r_stage_b),
    .sum_po (w_sum)
  );

  function automatic state_t f_next(input state_t s, input logic grant, input logic consume);
    state_t n;
    n = s;
    case (s)
      ST_IDLE:     if (grant) n = ST_INFLIGHT;
      ST_INFLIGHT: n = ST_RESP;
      ST_RESP:     if (consume) n = ST_IDLE;
      default:     n = ST_IDLE;
    endcase
    return n;
  endfunction

  always_ff @(posedge clk_pi or posedge rst_pi) begin
    if (rst_pi) begin
      r_state0 <= ST_IDLE;
      r_state1 <= ST_IDLE;
    end else begin
      r_state0 <= w_state0_nxt;
      r_state1 <= w_state1_nxt;
    end
  end

  always_comb begin
    w_state0_nxt = f_next(r_state0, w_grant0, rsp0_ready_pi);
    w_state1_nxt = f_next(r_state1, w_grant1, rsp1_ready_pi);
  end

  // Ties go to the port that was not granted last.
  always_comb begin
    w_elig0            = req0_valid_pi && (r_state0 == ST_IDLE);
    w_elig1            = req1_valid_pi && (r_state1 == ST_IDLE);
    w_grant0           = w_elig0 && (!w_elig1 || r_last_grant);
    w_grant1           = w_elig1 && (!w_elig0 || !r_last_grant);
    w_hs               = w_grant0 || w_grant1;
    req0_ready_po      = w_grant0;
    req1_ready_po      = w_grant1;
    rsp0_valid_po      = (r_state0 == ST_RESP);
    rsp1_valid_po      = (r_state1 == ST_RESP);
    rsp0_result_po     = r_result0;
    rsp1_result_po     = r_result1;
    dbg_state0_po      = r_state0;
    dbg_state1_po      = r_state1;
    dbg_stage_valid_po = r_stage_valid;
  end

  always_ff @(posedge clk_pi or posedge rst_pi) begin
    if (rst_pi) begin
      r_last_grant  <= 1'b1;
      r_stage_valid <= 1'b0;
      r_stage_tag   <= 1'b0;
      r_stage_a     <= '0;
      r_stage_b     <= '0;
      r_result0     <= '0;
      r_result1     <= '0;
    end else begin
      r_stage_valid <= w_hs;
      if (w_hs) begin
        r_last_grant <= w_grant1;
        r_stage_tag  <= w_grant1;
        r_stage_a    <= w_grant1 ? req1_a_pi : req0_a_pi;
        r_stage_b    <= w_grant1 ? req1_b_pi : req0_b_pi;
      end
      // The tagged port is INFLIGHT here, so its result register is never live.
      if (r_stage_valid && !r_stage_tag) r_result0 <= w_sum;
      if (r_stage_valid &&  r_stage_tag) r_result1 <= w_sum;
    end
  end
endmodule
